// File: rtl/atm_session_ctrl.sv
// ATM session controller: N-entry account table with a card -> PIN -> menu session FSM, PIN lockout and idle timeout.
// Each accepted input gives one resp_valid pulse on the next cycle; ready drops only during that RESP cycle.
`timescale 1ns/1ps
module atm_session_ctrl #(
  parameter int NUM_ACC     = 10,
  parameter int ACC_W       = 12,
  parameter int PIN_W       = 4,
  parameter int BAL_W       = 16,
  parameter int AMT_W       = 11,
  parameter int INIT_BAL    = 500,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IDX_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [ACC_W-1:0] cfg_acc,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] card_acc,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [AMT_W-1:0] op_amount,
  input  logic [ACC_W-1:0] op_dest_acc,
  input  logic             exit,
  output logic             ready,
  output logic             session_active,
  output logic             resp_valid,
  output logic [2:0]       resp_code,
  output logic [BAL_W-1:0] resp_balance
);
  localparam int TR_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] RC_OK        = 3'd0;
  localparam logic [2:0] RC_NOT_FOUND = 3'd1;
  localparam logic [2:0] RC_BAD_PIN   = 3'd2;
  localparam logic [2:0] RC_LOCKED    = 3'd3;
  localparam logic [2:0] RC_INSUFF    = 3'd4;
  localparam logic [2:0] RC_OVERFLOW  = 3'd5;
  localparam logic [2:0] RC_BAD_DEST  = 3'd6;
  localparam logic [2:0] RC_TIMEOUT   = 3'd7;

  localparam logic [2:0] OP_BALANCE  = 3'd0;
  localparam logic [2:0] OP_WITHDRAW = 3'd1;
  localparam logic [2:0] OP_DEPOSIT  = 3'd2;
  localparam logic [2:0] OP_TRANSFER = 3'd3;
  localparam logic [2:0] OP_LOGOUT   = 3'd4;

  // Encoded so that bit 1 is ready and bit 2 is session_active straight off the state flops.
  typedef enum logic [2:0] {
    S_IDLE     = 3'b010,
    S_PIN_WAIT = 3'b110,
    S_MENU     = 3'b111,
    S_RESP     = 3'b100
  } state_t;

  state_t           state, ret_state;
  logic [IDX_W-1:0] cur_idx;
  logic [TR_W-1:0]  tries;
  logic [TO_W-1:0]  idle_cnt;

  logic [ACC_W-1:0] ent_acc [NUM_ACC];
  logic [PIN_W-1:0] ent_pin [NUM_ACC];
  logic [BAL_W-1:0] ent_bal [NUM_ACC];
  logic [NUM_ACC-1:0] ent_vld, ent_lock;

  logic             card_hit, dest_hit, accept, amt_bad, idle_expired;
  logic [IDX_W-1:0] card_idx, dest_idx;
  logic [BAL_W-1:0] cur_bal, dst_bal, amt, wd_bal;
  logic [BAL_W:0]   dep_sum, xfer_sum;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    card_hit = 1'b0;
    card_idx = '0;
    dest_hit = 1'b0;
    dest_idx = '0;
    for (int i = NUM_ACC - 1; i >= 0; i--) begin
      if (ent_vld[i] && ent_acc[i] == card_acc) begin
        card_hit = 1'b1;
        card_idx = IDX_W'(i);
      end
      if (ent_vld[i] && ent_acc[i] == op_dest_acc) begin
        dest_hit = 1'b1;
        dest_idx = IDX_W'(i);
      end
    end
  end

  assign ready          = state[1];
  assign session_active = state[2];

  assign cur_bal      = ent_bal[cur_idx];
  assign dst_bal      = ent_bal[dest_idx];
  assign amt          = BAL_W'(op_amount);
  assign wd_bal       = cur_bal - amt;
  assign dep_sum      = {1'b0, cur_bal} + {1'b0, amt};
  assign xfer_sum     = {1'b0, dst_bal} + {1'b0, amt};
  assign amt_bad      = (op_amount == '0) || (amt > cur_bal);
  assign accept       = (state == S_PIN_WAIT) ? pin_valid : op_valid;
  assign idle_expired = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ret_state    <= S_IDLE;
      cur_idx      <= '0;
      tries        <= '0;
      idle_cnt     <= '0;
      resp_valid   <= 1'b0;
      resp_code    <= RC_OK;
      resp_balance <= '0;
      ent_vld      <= '0;
      ent_lock     <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        ent_acc[i] <= '0;
        ent_pin[i] <= '0;
        ent_bal[i] <= BAL_W'(INIT_BAL);
      end
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_we) begin
            if (int'(cfg_idx) < NUM_ACC) begin
              ent_acc[cfg_idx]  <= cfg_acc;
              ent_pin[cfg_idx]  <= cfg_pin;
              ent_vld[cfg_idx]  <= 1'b1;
              ent_lock[cfg_idx] <= 1'b0;
            end
          end else if (card_valid) begin
            if (!card_hit || ent_lock[card_idx]) begin
              resp_valid   <= 1'b1;
              resp_code    <= card_hit ? RC_LOCKED : RC_NOT_FOUND;
              resp_balance <= '0;
              ret_state    <= S_IDLE;
              state        <= S_RESP;
            end else begin
              cur_idx  <= card_idx;
              tries    <= '0;
              idle_cnt <= '0;
              state    <= S_PIN_WAIT;
            end
          end
        end
        S_PIN_WAIT, S_MENU: begin
          // Exit and timeout share the defaults below; an accepted pin/op overrides them.
          if (exit || accept || idle_expired) begin
            resp_valid   <= 1'b1;
            resp_code    <= RC_OK;
            resp_balance <= cur_bal;
            ret_state    <= S_IDLE;
            state        <= S_RESP;
            idle_cnt     <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (!exit) begin
            if (accept && state == S_PIN_WAIT) begin
              if (pin == ent_pin[cur_idx]) begin
                tries     <= '0;
                ret_state <= S_MENU;
              end else if (tries == TR_W'(MAX_TRIES - 1)) begin
                tries             <= '0;
                ent_lock[cur_idx] <= 1'b1;
                resp_code         <= RC_LOCKED;
              end else begin
                tries     <= tries + 1'b1;
                resp_code <= RC_BAD_PIN;
                ret_state <= S_PIN_WAIT;
              end
            end else if (accept) begin
              ret_state <= S_MENU;
              case (op_code)
                OP_BALANCE: resp_code <= RC_OK;
                OP_WITHDRAW: begin
                  if (amt_bad) begin
                    resp_code <= RC_INSUFF;
                  end else begin
                    ent_bal[cur_idx] <= wd_bal;
                    resp_balance     <= wd_bal;
                  end
                end
                OP_DEPOSIT: begin
                  if (dep_sum[BAL_W]) begin
                    resp_code <= RC_OVERFLOW;
                  end else begin
                    ent_bal[cur_idx] <= dep_sum[BAL_W-1:0];
                    resp_balance     <= dep_sum[BAL_W-1:0];
                  end
                end
                OP_TRANSFER: begin
                  if (!dest_hit || dest_idx == cur_idx) begin
                    resp_code <= RC_BAD_DEST;
                  end else if (amt_bad) begin
                    resp_code <= RC_INSUFF;
                  end else if (xfer_sum[BAL_W]) begin
                    resp_code <= RC_OVERFLOW;
                  end else begin
                    ent_bal[cur_idx]  <= wd_bal;
                    ent_bal[dest_idx] <= xfer_sum[BAL_W-1:0];
                    resp_balance      <= wd_bal;
                  end
                end
                OP_LOGOUT: ret_state <= S_IDLE;
                default:   resp_code <= RC_BAD_DEST;
              endcase
            end else if (idle_expired) begin
              resp_code <= RC_TIMEOUT;
            end
          end
        end
        S_RESP:  state <= ret_state;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: directed sessions plus random traffic checked against a transaction-level account model.
`timescale 1ns/1ps
module tb_atm_session_ctrl;
  localparam int NUM_ACC     = 10;
  localparam int ACC_W       = 12;
  localparam int PIN_W       = 4;
  localparam int BAL_W       = 16;
  localparam int AMT_W       = 11;
  localparam int INIT_BAL    = 500;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int IDX_W       = 4;
  localparam int MAX_BAL     = (1 << BAL_W) - 1;

  localparam logic [2:0] RC_OK = 3'd0, RC_NOT_FOUND = 3'd1, RC_BAD_PIN = 3'd2, RC_LOCKED = 3'd3;
  localparam logic [2:0] RC_INSUFF = 3'd4, RC_OVERFLOW = 3'd5, RC_BAD_DEST = 3'd6, RC_TIMEOUT = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we, card_valid, pin_valid, op_valid, exit;
  logic [IDX_W-1:0] cfg_idx;
  logic [ACC_W-1:0] cfg_acc, card_acc, op_dest_acc;
  logic [PIN_W-1:0] cfg_pin, pin;
  logic [2:0]       op_code;
  logic [AMT_W-1:0] op_amount;
  logic             ready, session_active, resp_valid;
  logic [2:0]       resp_code;
  logic [BAL_W-1:0] resp_balance;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .AMT_W(AMT_W),
    .INIT_BAL(INIT_BAL), .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acc(cfg_acc), .cfg_pin(cfg_pin),
    .card_valid(card_valid), .card_acc(card_acc),
    .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op_code(op_code), .op_amount(op_amount), .op_dest_acc(op_dest_acc),
    .exit(exit),
    .ready(ready), .session_active(session_active),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_balance(resp_balance)
  );

  typedef struct packed {
    logic [2:0]       code;
    logic [BAL_W-1:0] bal;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_seen = 0;

  // Account model: one customer phase plus plain arrays for the table.
  typedef enum {PH_IDLE, PH_PIN, PH_MENU} ph_t;
  ph_t ph = PH_IDLE;
  int  m_acc [NUM_ACC];
  int  m_pin [NUM_ACC];
  int  m_bal [NUM_ACC];
  bit  m_vld [NUM_ACC];
  bit  m_lock[NUM_ACC];
  int  cur = 0;
  int  tries = 0;

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) begin
      m_acc[i] = 0; m_pin[i] = 0; m_bal[i] = INIT_BAL; m_vld[i] = 0; m_lock[i] = 0;
    end
    ph = PH_IDLE; cur = 0; tries = 0;
  endtask

  function automatic int find(input int acc);
    for (int i = 0; i < NUM_ACC; i++)
      if (m_vld[i] && m_acc[i] == acc) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cfg_we = 0; card_valid = 0; pin_valid = 0; op_valid = 0; exit = 0;
    cfg_idx = '0; cfg_acc = '0; cfg_pin = '0; card_acc = '0; pin = '0;
    op_code = '0; op_amount = '0; op_dest_acc = '0;
  endtask

  task automatic push_exp(input logic [2:0] c, input int b);
    exp_t e;
    e.code = c;
    e.bal  = BAL_W'(b);
    exp_q.push_back(e);
  endtask

  // Inputs are already on the pins; update the model, let the DUT sample them, then wait out any response.
  task automatic issue();
    bit         r;
    logic [2:0] c;
    int         b, f, a, tgt, n;
    r = 0; c = RC_OK; b = 0;
    a = int'(op_amount);
    case (ph)
      PH_IDLE: begin
        if (cfg_we) begin
          if (int'(cfg_idx) < NUM_ACC) begin
            m_acc[cfg_idx] = int'(cfg_acc); m_pin[cfg_idx] = int'(cfg_pin);
            m_vld[cfg_idx] = 1; m_lock[cfg_idx] = 0;
          end
        end else if (card_valid) begin
          f = find(int'(card_acc));
          if (f < 0) begin r = 1; c = RC_NOT_FOUND; end
          else if (m_lock[f]) begin r = 1; c = RC_LOCKED; end
          else begin cur = f; tries = 0; ph = PH_PIN; end
        end
      end
      PH_PIN: begin
        if (exit || pin_valid) begin
          r = 1;
          if (exit) ph = PH_IDLE;
          else if (int'(pin) == m_pin[cur]) begin tries = 0; ph = PH_MENU; end
          else begin
            tries++;
            if (tries == MAX_TRIES) begin m_lock[cur] = 1; c = RC_LOCKED; tries = 0; ph = PH_IDLE; end
            else c = RC_BAD_PIN;
          end
          b = m_bal[cur];
        end
      end
      PH_MENU: begin
        if (exit || op_valid) begin
          r = 1;
          if (exit) ph = PH_IDLE;
          else begin
            case (int'(op_code))
              0: c = RC_OK;
              1: if (a == 0 || a > m_bal[cur]) c = RC_INSUFF; else m_bal[cur] -= a;
              2: if (m_bal[cur] + a > MAX_BAL) c = RC_OVERFLOW; else m_bal[cur] += a;
              3: begin
                f = find(int'(op_dest_acc));
                if (f < 0 || f == cur) c = RC_BAD_DEST;
                else if (a == 0 || a > m_bal[cur]) c = RC_INSUFF;
                else if (m_bal[f] + a > MAX_BAL) c = RC_OVERFLOW;
                else begin m_bal[cur] -= a; m_bal[f] += a; end
              end
              4: ph = PH_IDLE;
              default: c = RC_BAD_DEST;
            endcase
          end
          b = m_bal[cur];
        end
      end
      default: ph = PH_IDLE;
    endcase
    if (r) push_exp(c, b);
    tgt = resp_seen + (r ? 1 : 0);
    @(posedge clk); #1;
    clear_inputs();
    n = 0;
    while (resp_seen < tgt && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (r) chk("resp_arrived", resp_seen >= tgt, 1);
  endtask

  task automatic do_cfg(input int idx, input int acc, input int p);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_acc = ACC_W'(acc); cfg_pin = PIN_W'(p);
    issue();
  endtask

  task automatic do_card(input int acc);
    card_valid = 1; card_acc = ACC_W'(acc);
    issue();
  endtask

  task automatic do_pin(input int p);
    pin_valid = 1; pin = PIN_W'(p);
    issue();
  endtask

  task automatic do_op(input int oc, input int amt = 0, input int dest = 0, input bit ex = 0);
    op_valid = 1; op_code = 3'(oc); op_amount = AMT_W'(amt); op_dest_acc = ACC_W'(dest); exit = ex;
    issue();
  endtask

  task automatic do_exit();
    exit = 1;
    issue();
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_session_active", session_active, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_code", resp_code, 0);
    chk("rst_resp_balance", resp_balance, 0);
  endtask

  // Stay silent from a session state and expect a TIMEOUT after exactly TIMEOUT_CYC cycles.
  task automatic idle_timeout(input string name);
    int n;
    push_exp(RC_TIMEOUT, m_bal[cur]);
    ph = PH_IDLE;
    n = 0;
    while (n < TIMEOUT_CYC + 5 && resp_valid !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, TIMEOUT_CYC);
    @(posedge clk); #1;
    chk("timeout_session_active", session_active, 0);
    chk("timeout_ready", ready, 1);
  endtask

  function automatic int rand_amt();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return int'($urandom_range(1, 300));
      2: return 2047;
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    int seen0, k;
    clear_inputs();
    model_reset();
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && resp_valid) begin
          resp_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got code %0d bal %0d, expected no response", resp_code, resp_balance);
          end else begin
            e = exp_q.pop_front();
            if (resp_code !== e.code || resp_balance !== e.bal) begin
              errors++;
              $display("FAIL resp: got code %0d bal %0d, expected code %0d bal %0d",
                       resp_code, resp_balance, e.code, e.bal);
            end
          end
        end
      end
      begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Directed walk through the main session flows.
    do_cfg(0, 2749, 0);
    do_card(2749);
    chk("pin_wait_session_active", session_active, 1);
    do_pin(0);
    do_op(0);
    do_op(1, 600);
    do_op(1, 200);
    do_op(1, 0);
    do_op(6);
    do_op(4);
    do_cfg(1, 2175, 5);
    do_card(2749); do_pin(0);
    do_op(3, 100, 2175);
    do_op(3, 100, 4000);
    do_op(3, 100, 2749);
    do_op(4);
    do_card(2175); do_pin(5); do_op(0); do_op(4);
    do_card(2175); do_pin(1); do_pin(2); do_pin(3);
    do_card(2175);
    do_cfg(1, 2175, 5);
    do_card(2175); do_pin(5); do_op(4);
    do_card(2749); do_pin(0);
    repeat (35) do_op(2, 2047);
    do_op(1, 50, 0, 1);
    chk("exit_session_active", session_active, 0);
    do_card(999);

    // Random traffic against the model.
    for (int t = 0; t < 400; t++) begin
      k = int'($urandom_range(0, 99));
      case (ph)
        PH_IDLE: begin
          if (k < 20) do_cfg(int'($urandom_range(0, 11)), 100 + int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
          else if (k < 25) begin
            card_valid = 1; card_acc = ACC_W'(100 + $urandom_range(0, 7));
            do_cfg(int'($urandom_range(0, 9)), 100 + int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
          end else do_card(100 + int'($urandom_range(0, 7)));
        end
        PH_PIN: begin
          if (k < 5) do_exit();
          else if (k < 10) do_op(0);
          else do_pin(int'($urandom_range(0, 3)));
        end
        default: begin
          if (k < 5) do_exit();
          else if (k < 8) do_pin(0);
          else do_op(int'($urandom_range(0, 7)), rand_amt(), 100 + int'($urandom_range(0, 7)), k < 10);
        end
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    // Timeouts from MENU and PIN_WAIT.
    if (ph == PH_MENU || ph == PH_PIN) do_exit();
    do_cfg(0, 2749, 0);
    do_card(2749); do_pin(0); do_op(0);
    idle_timeout("menu_timeout_cycles");
    do_card(2749);
    idle_timeout("pin_timeout_cycles");

    // Reset while an operation is on the pins: it must vanish and the table must reinitialise.
    do_card(2749); do_pin(0); do_op(2, 77);
    seen0 = resp_seen;
    op_valid = 1; op_code = 3'd1; op_amount = 11'd50;
    #3 rst_n = 0;
    model_reset();
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resp_across_reset", resp_seen - seen0, 0);
    do_card(2749);
    do_cfg(0, 2749, 0);
    do_cfg(3, 2175, 5);
    do_card(2749); do_pin(0); do_op(0); do_op(4);
    do_card(2175); do_pin(5); do_op(0); do_op(4);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
